// File: rtl/mux_2to1_df.sv
`default_nettype none
// ============================================================================
// Module   : mux_2to1_df
// Brief    : Dataflow 2-to-1 mux with a registered copy of the result and a
//            saturating counter of Select transitions.
// Revision : 1.0 - initial release
// ============================================================================
module mux_2to1_df #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    output logic [WIDTH-1:0] Out,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             Select,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] sel_changes
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [WIDTH-1:0] r_out_q;
    logic             r_out_valid;
    logic             r_sel_prev;
    logic [CNT_W-1:0] r_sel_changes;
    logic             w_sel_toggled;

    // Plain ?: keeps X-propagation on Select: agreeing bits stay known.
    assign Out = Select ? In2 : In1;

    // The first post-reset sample has no valid predecessor, so it never counts.
    assign w_sel_toggled = r_out_valid && (Select != r_sel_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q       <= '0;
            r_out_valid   <= 1'b0;
            r_sel_prev    <= 1'b0;
            r_sel_changes <= '0;
        end else begin
            r_out_q     <= Out;
            r_out_valid <= 1'b1;
            r_sel_prev  <= Select;
            if (w_sel_toggled && (r_sel_changes != c_cnt_max)) begin
                r_sel_changes <= r_sel_changes + 1'b1;
            end
        end
    end

    assign out_q       = r_out_q;
    assign out_valid   = r_out_valid;
    assign sel_changes = r_sel_changes;

endmodule
`default_nettype wire

// File: tb/tb_mux_2to1_df.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_2to1_df
// Brief    : Bench for mux_2to1_df; a 1-bit/8-bit-counter instance and an
//            8-bit/2-bit-counter instance share clock, reset and Select.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_2to1_df;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       in1_a = 1'b0, in2_a = 1'b0;
    logic [7:0] in1_w = '0, in2_w = '0;

    logic       out_a, q_a, v_a;
    logic [7:0] cnt_a;
    logic [7:0] out_w, q_w;
    logic       v_w;
    logic [1:0] cnt_w;

    int checks = 0;
    int errors = 0;

    // Reference model: list of Select samples since last reset, plus the
    // mux result captured on the last edge.
    bit         hist[$];
    logic       exp_q_a = 1'b0;
    logic [7:0] exp_q_w = '0;

    mux_2to1_df dut_a (
        .Out(out_a), .In1(in1_a), .In2(in2_a), .Select(sel),
        .clk(clk), .rst(rst),
        .out_q(q_a), .out_valid(v_a), .sel_changes(cnt_a)
    );

    mux_2to1_df #(.WIDTH(8), .CNT_W(2)) dut_w (
        .Out(out_w), .In1(in1_w), .In2(in2_w), .Select(sel),
        .clk(clk), .rst(rst),
        .out_q(q_w), .out_valid(v_w), .sel_changes(cnt_w)
    );

    always #5 clk = ~clk;

    function automatic int transitions();
        int n = 0;
        for (int i = 1; i < hist.size(); i++)
            if (hist[i] != hist[i-1]) n++;
        return n;
    endfunction

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            hist.delete();
            exp_q_a = 1'b0;
            exp_q_w = 8'h00;
        end else begin
            hist.push_back(sel);
            exp_q_a = sel ? in2_a : in1_a;
            exp_q_w = sel ? in2_w : in1_w;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sel = 1'b1; in1_a = 1'b0; in2_a = 1'b1;
        tick(); tick();
        checks++;
        if (q_a !== 1'b0 || v_a !== 1'b0 || cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_a: q=%b v=%b cnt=%0d required 0 0 0", q_a, v_a, cnt_a);
        end
        checks++;
        if (q_w !== 8'h00 || v_w !== 1'b0 || cnt_w !== 2'd0) begin
            errors++;
            $display("FAIL reset_w: q=%h v=%b cnt=%0d required 00 0 0", q_w, v_w, cnt_w);
        end
        checks++;
        if (out_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb: Out=%b required 1", out_a);
        end
    endtask

    task automatic test_truth_table();
        logic exp;
        for (int i = 0; i < 8; i++) begin
            {sel, in1_a, in2_a} = 3'(i);
            #50;
            exp = sel ? in2_a : in1_a;
            checks++;
            if (out_a !== exp) begin
                errors++;
                $display("FAIL truth_%0d: Out=%b required %b", i, out_a, exp);
            end
        end
    endtask

    task automatic test_registered_path();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (v_a !== 1'b0) begin
            errors++;
            $display("FAIL regpath_valid_in_reset: valid=%b required 0", v_a);
        end
        rst = 1'b0; in1_a = 1'b1; in2_a = 1'b0; sel = 1'b0;
        tick();
        checks++;
        if (q_a !== 1'b1 || v_a !== 1'b1) begin
            errors++;
            $display("FAIL regpath_first: q=%b v=%b required 1 1", q_a, v_a);
        end
        sel = 1'b1;
        #1;
        checks++;
        if (out_a !== 1'b0 || q_a !== 1'b1) begin
            errors++;
            $display("FAIL regpath_comb: Out=%b q=%b required 0 1", out_a, q_a);
        end
        tick();
        checks++;
        if (q_a !== 1'b0) begin
            errors++;
            $display("FAIL regpath_delayed: q=%b required 0", q_a);
        end
    endtask

    task automatic test_sel_counter();
        rst = 1'b1; sel = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            sel = ~sel;
            tick();
        end
        checks++;
        if (cnt_a !== 8'd5) begin
            errors++;
            $display("FAIL counter_5: cnt=%0d required 5", cnt_a);
        end
        tick(); tick(); tick();
        checks++;
        if (cnt_a !== 8'd5) begin
            errors++;
            $display("FAIL counter_hold: cnt=%0d required 5", cnt_a);
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1; sel = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            sel = ~sel;
            tick();
        end
        checks++;
        if (cnt_w !== 2'd3 || cnt_a !== 8'd10) begin
            errors++;
            $display("FAIL saturation: cnt_w=%0d cnt_a=%0d required 3 10", cnt_w, cnt_a);
        end
        for (int i = 0; i < 4; i++) begin
            sel = ~sel;
            tick();
        end
        checks++;
        if (cnt_w !== 2'd3) begin
            errors++;
            $display("FAIL saturation_stay: cnt_w=%0d required 3", cnt_w);
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; sel = 1'b0;
        tick();
        rst = 1'b0;
        in1_a = 1'b1; in2_a = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            sel = ~sel;
            tick();
        end
        checks++;
        if (cnt_a !== 8'd4 || q_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: cnt=%0d q=%b required 4 1", cnt_a, q_a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_comb: Out=%b required 1", out_a);
        end
        tick();
        checks++;
        if (cnt_a !== 8'd0 || q_a !== 1'b0 || v_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_post: cnt=%0d q=%b v=%b required 0 0 0", cnt_a, q_a, v_a);
        end
        rst = 1'b0;
    endtask

    task automatic test_wide_data();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in1_w = 8'hA5; in2_w = 8'h3C; sel = 1'b0;
        #1;
        checks++;
        if (out_w !== 8'hA5) begin
            errors++;
            $display("FAIL wide_sel0: Out=%h required a5", out_w);
        end
        tick();
        checks++;
        if (q_w !== 8'hA5) begin
            errors++;
            $display("FAIL wide_q0: q=%h required a5", q_w);
        end
        sel = 1'b1;
        #1;
        checks++;
        if (out_w !== 8'h3C || q_w !== 8'hA5) begin
            errors++;
            $display("FAIL wide_sel1: Out=%h q=%h required 3c a5", out_w, q_w);
        end
        tick();
        checks++;
        if (q_w !== 8'h3C) begin
            errors++;
            $display("FAIL wide_q1: q=%h required 3c", q_w);
        end
    endtask

    task automatic test_random();
        logic       exp_a;
        logic [7:0] exp_w;
        for (int n = 0; n < 300; n++) begin
            rst   = ($urandom_range(0, 39) == 0);
            sel   = $urandom_range(0, 1) == 1;
            in1_a = $urandom_range(0, 1) == 1;
            in2_a = $urandom_range(0, 1) == 1;
            in1_w = 8'($urandom);
            in2_w = 8'($urandom);
            #1;
            exp_a = sel ? in2_a : in1_a;
            exp_w = sel ? in2_w : in1_w;
            checks++;
            if (out_a !== exp_a || out_w !== exp_w) begin
                errors++;
                $display("FAIL rand_comb_%0d: Out=%b/%h required %b/%h", n, out_a, out_w, exp_a, exp_w);
            end
            tick();
            checks++;
            if (q_a !== exp_q_a || q_w !== exp_q_w ||
                v_a !== (hist.size() > 0) || v_w !== (hist.size() > 0)) begin
                errors++;
                $display("FAIL rand_reg_%0d: q=%b/%h v=%b/%b required %b/%h %b",
                         n, q_a, q_w, v_a, v_w, exp_q_a, exp_q_w, hist.size() > 0);
            end
            checks++;
            if (int'(cnt_a) != sat(transitions(), 255) || int'(cnt_w) != sat(transitions(), 3)) begin
                errors++;
                $display("FAIL rand_cnt_%0d: cnt=%0d/%0d required %0d/%0d",
                         n, cnt_a, cnt_w, sat(transitions(), 255), sat(transitions(), 3));
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_truth_table();
        test_registered_path();
        test_sel_counter();
        test_saturation();
        test_mid_reset();
        test_wide_data();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
